// File: rtl/sigma_delta_pkg.sv
// Shared sizing and saturation helpers for the sigma-delta DAC and decimator paths.
package sigma_delta_pkg;

  function automatic int acc_width(input int decim_log2);
    return 2 * decim_log2 + 1;
  endfunction

  // Positive result is a right shift, negative a left shift.
  function automatic int scale_shift(input int decim_log2, input int data_n);
    return 2 * decim_log2 - data_n;
  endfunction

  function automatic logic [31:0] saturate(input logic [31:0] value, input int data_n);
    logic [31:0] max_val;
    max_val = (32'd1 << data_n) - 32'd1;
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/sd_sample_buffer.sv
// One-entry valid/ready holding register; a sample arriving while the entry is
// occupied and not being consumed is dropped and latches a sticky overrun flag.
module sd_sample_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (push) begin
      if (!valid || ready) begin
        data  <= push_data;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sigma_delta_decimator.sv
// Second-order CIC decimator: 1-bit stream in, saturated DATA_N-bit samples out
// through a one-entry valid/ready buffer. Sample visible two cycles after frame end.
module sigma_delta_decimator
  import sigma_delta_pkg::*;
#(
  parameter int DATA_N     = 8,
  parameter int DECIM_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bitIn,
  input  logic              bitValid,
  output logic [DATA_N-1:0] dataOut,
  output logic              dataValid,
  input  logic              dataReady,
  output logic              overrun
);

  localparam int W     = acc_width(DECIM_LOG2);
  localparam int SHIFT = scale_shift(DECIM_LOG2, DATA_N);
  localparam int SH_R  = (SHIFT > 0) ? SHIFT : 0;
  localparam int SH_L  = (SHIFT < 0) ? -SHIFT : 0;

  logic [W-1:0]          int1, int2, int1_next, int2_next;
  logic [W-1:0]          frame_int2, int2_prev, c1_prev, c1, comb_out;
  logic [DECIM_LOG2-1:0] frame_cnt;
  logic                  frame_done, warm, push;
  logic [31:0]           scaled;
  logic [DATA_N-1:0]     sample;

  assign int1_next = int1 + W'(bitIn);
  assign int2_next = int2 + int1_next;

  // All accumulator arithmetic wraps modulo 2^W; the comb differences undo it.
  assign c1       = frame_int2 - int2_prev;
  assign comb_out = c1 - c1_prev;
  assign scaled   = (32'(comb_out) >> SH_R) << SH_L;
  assign sample   = DATA_N'(saturate(scaled, DATA_N));
  assign push     = frame_done && warm;

  always_ff @(posedge clk) begin
    if (reset) begin
      int1       <= '0;
      int2       <= '0;
      frame_cnt  <= '0;
      frame_int2 <= '0;
      frame_done <= 1'b0;
      int2_prev  <= '0;
      c1_prev    <= '0;
      warm       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bitValid) begin
        int1      <= int1_next;
        int2      <= int2_next;
        frame_cnt <= frame_cnt + DECIM_LOG2'(1);
        if (frame_cnt == '1) begin
          frame_int2 <= int2_next;
          frame_done <= 1'b1;
        end
      end
      // The first comb result after reset lacks history and is not pushed.
      if (frame_done) begin
        int2_prev <= frame_int2;
        c1_prev   <= c1;
        warm      <= 1'b1;
      end
    end
  end

  sd_sample_buffer #(.WIDTH(DATA_N)) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (sample),
    .data      (dataOut),
    .valid     (dataValid),
    .ready     (dataReady),
    .overrun   (overrun)
  );

endmodule
